// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings and constants for the word-access unit.
// Rev 1.0
`default_nettype none

package mem_access_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic CS_SELECT = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic WR_READ   = 1'b0;
  localparam logic WR_WRITE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_word_access_unit.sv
// mem_word_access_unit: splits a 16-bit load/store into two byte accesses (A, A+1).
// Build macro MEM_WORD_BIG_ENDIAN_EN selects big-endian byte order. Rev 1.0
`default_nettype none

module mem_word_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = mem_access_pkg::ADDR_W,
  parameter int DATA_W = mem_access_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [2*DATA_W-1:0]   resp_rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data,
  output logic                  mem_wr,
  output logic                  mem_cs,
  input  logic [DATA_W-1:0]     mem_o
);

  localparam int WORD_W = 2 * DATA_W;

`ifdef MEM_WORD_BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  state_t            state;
  logic [WORD_W-1:0] wdata;
  logic [DATA_W-1:0] first_wbyte;

  // The byte lane that travels on address A depends on the build's byte order.
  assign first_wbyte = BIG_ENDIAN ? req_wdata[WORD_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      wdata       <= '0;
      mem_cs      <= CS_IDLE;
      mem_wr      <= WR_READ;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            wdata       <= req_wdata;
            mem_address <= req_addr;
            mem_data    <= first_wbyte;
            mem_wr      <= req_write;
            mem_cs      <= CS_SELECT;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= LO;
          end
        end
        LO: begin
          if (mem_wr == WR_READ) begin
            if (BIG_ENDIAN) resp_rdata[WORD_W-1:DATA_W] <= mem_o;
            else            resp_rdata[DATA_W-1:0]      <= mem_o;
          end
          // Increment wraps modulo 2^ADDR_W by construction.
          mem_address <= mem_address + ADDR_W'(1);
          mem_data    <= BIG_ENDIAN ? wdata[DATA_W-1:0] : wdata[WORD_W-1:DATA_W];
          state       <= HI;
        end
        HI: begin
          if (mem_wr == WR_READ) begin
            if (BIG_ENDIAN) resp_rdata[DATA_W-1:0]      <= mem_o;
            else            resp_rdata[WORD_W-1:DATA_W] <= mem_o;
          end
          mem_cs     <= CS_IDLE;
          mem_wr     <= WR_READ;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_word_access_unit.sv
// tb_mem_word_access_unit: directed self-checking bench with a 256-byte memory responder.
// Rev 1.0
`default_nettype none

module tb_mem_word_access_unit;

`ifdef MEM_WORD_BIG_ENDIAN_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        req_ready, resp_valid, busy, mem_wr, mem_cs;
  logic [15:0] resp_rdata, mem_address;
  logic [7:0]  mem_data;
  wire  [7:0]  mem_o;

  logic        init_ram = 1'b1;
  logic [7:0]  ram [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_word_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wr(mem_wr),
    .mem_cs(mem_cs), .mem_o(mem_o)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  // Memory responder: combinational read, write committed on the rising edge.
  assign mem_o = (!mem_cs && !mem_wr) ? ram[mem_address[7:0]] : 8'hzz;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (mem_cs == 1'b0 && mem_wr == 1'b1) begin
      ram[mem_address[7:0]] <= mem_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word request; lat is the edge (counted from accept) at which the requester
  // samples resp_valid high, -1 on timeout.
  task automatic run_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat,
                         output logic [15:0] a_lo, output logic [15:0] a_hi,
                         output logic wr_lo, output logic wr_hi, output logic pulse_after);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = 16'h0BAD; req_wdata = 16'h0F0F;
    a_lo = mem_address; wr_lo = mem_wr;
    @(posedge clk); #1;
    a_hi = mem_address; wr_hi = mem_wr;
    lat = -1; rd = 16'hxxxx;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = n + 1;
        rd  = resp_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    pulse_after = resp_valid;
  endtask

  logic [15:0] rd, a_lo, a_hi, acc_addr[2];
  logic        wr_lo, wr_hi, pulse, prev_cs, saw_resp;
  int          lat, accepts;

  initial begin
    // Reset and memory initialisation
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 16'h0000);
    check("rst_cs", mem_cs, 1'b1);
    check("rst_wr", mem_wr, 1'b0);
    check("rst_addr", mem_address, 16'h0000);
    check("rst_data", mem_data, 8'h00);
    @(negedge clk); init_ram = 1'b0; rst = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("idle_cs", mem_cs, 1'b1);
      check("idle_wr", mem_wr, 1'b0);
      check("idle_ready", req_ready, 1'b1);
      check("idle_resp_valid", resp_valid, 1'b0);
    end

    // Store/load at an aligned address
    run_req(1'b1, 16'h0010, 16'hBEEF, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("st_beef_lat", lat, 3);
    check("st_beef_addr_lo", a_lo, 16'h0010);
    check("st_beef_addr_hi", a_hi, 16'h0011);
    check("st_beef_wr_lo", wr_lo, 1'b1);
    check("st_beef_wr_hi", wr_hi, 1'b1);
    check("st_beef_pulse", pulse, 1'b0);
    check("st_beef_rdata_hold", resp_rdata, 16'h0000);
    check("st_beef_ram10", ram[8'h10], BE ? 8'hBE : 8'hEF);
    check("st_beef_ram11", ram[8'h11], BE ? 8'hEF : 8'hBE);
    run_req(1'b0, 16'h0010, 16'h0000, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("ld_beef_rdata", rd, 16'hBEEF);
    check("ld_beef_lat", lat, 3);
    check("ld_beef_wr_lo", wr_lo, 1'b0);
    check("ld_beef_pulse", pulse, 1'b0);
    check("ld_beef_ready", req_ready, 1'b1);

    // Odd address
    run_req(1'b1, 16'h0021, 16'h1234, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("st_odd_ram21", ram[8'h21], BE ? 8'h12 : 8'h34);
    check("st_odd_ram22", ram[8'h22], BE ? 8'h34 : 8'h12);
    check("st_odd_ram20", ram[8'h20], 8'hE3);
    check("st_odd_ram23", ram[8'h23], 8'hE0);
    run_req(1'b0, 16'h0021, 16'h0000, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("ld_odd_rdata", rd, 16'h1234);

    // Address wrap at 16'hFFFF
    run_req(1'b1, 16'hFFFF, 16'hA55A, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("st_wrap_addr_hi", a_hi, 16'h0000);
    check("st_wrap_ramFF", ram[8'hFF], BE ? 8'hA5 : 8'h5A);
    check("st_wrap_ram00", ram[8'h00], BE ? 8'h5A : 8'hA5);
    run_req(1'b0, 16'hFFFF, 16'h0000, rd, lat, a_lo, a_hi, wr_lo, wr_hi, pulse);
    check("ld_wrap_rdata", rd, 16'hA55A);

    // Back-to-back loads with req_addr changing every cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0050;
    accepts = 0; prev_cs = mem_cs;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (prev_cs && !mem_cs) begin
        if (accepts < 2) acc_addr[accepts] = mem_address;
        accepts++;
      end
      prev_cs = mem_cs;
      req_addr = 16'h0050 + 16'(2 * n);
    end
    req_valid = 1'b0;
    check("b2b_accepts", accepts, 2);
    check("b2b_addr0", acc_addr[0], 16'h0050);
    check("b2b_addr1", acc_addr[1], 16'h0058);

    // Reset while the low byte of a store is being committed
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'hCAFE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_cs", mem_cs, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    saw_resp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    check("rst_mid_no_resp", saw_resp, 1'b0);
    check("rst_mid_ram40", ram[8'h40], BE ? 8'hCA : 8'hFE);
    check("rst_mid_ram41", ram[8'h41], 8'h82);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
